// File: rtl/if_id_buffer_pkg.sv
// ============================================================================
// Module      : if_id_buffer_pkg
// Description : Shared CPU constants and the IF/ID buffer entry type.
//               Entry carries an alignment flag only with IF_ID_ALIGN_CHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_id_buffer_pkg;

  localparam logic [31:0] PC_RESET      = 32'h8000_0000;
  localparam logic [31:0] INS_NOP       = 32'h0000_0000;
  localparam int          DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
`ifdef IF_ID_ALIGN_CHK_EN
    logic        adel;
`endif
  } if_id_entry_t;

endpackage : if_id_buffer_pkg

`default_nettype wire

// File: rtl/if_id_buffer.sv
// ============================================================================
// Module      : if_id_buffer
// Description : In-order FIFO decoupling fetch from decode, with a registered
//               fetch bubble. Optional macro IF_ID_ALIGN_CHK_EN adds a
//               misaligned-PC flag (id_exc_adel) per entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  input  logic [PC_W-1:0] if_ins,
  input  logic            if_ins_valid,
  input  logic            id_stall,
  input  logic            flush,
  output logic            if_bubble,
  output logic            id_valid,
  output logic [PC_W-1:0] id_pc,
  output logic [PC_W-1:0] id_ins,
`ifdef IF_ID_ALIGN_CHK_EN
  output logic            id_exc_adel,
`endif
  output logic            overflow
);

  localparam int c_CW = $clog2(DEPTH + 1);
  localparam int c_PW = $clog2(DEPTH);

  if_id_entry_t    r_mem [DEPTH];
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;
  logic            r_bubble;
  logic            r_overflow;

  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [c_CW-1:0] w_count_next;
  if_id_entry_t    w_new;

  function automatic logic [c_PW-1:0] f_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full = (r_count == c_CW'(DEPTH));
  assign w_push = if_ins_valid & ~flush & ~w_full;
  assign w_pop  = id_valid & ~id_stall & ~flush;

  assign w_count_next = flush ? '0 : (r_count + c_CW'(w_push) - c_CW'(w_pop));

  always_comb begin
    w_new     = '0;
    w_new.pc  = if_pc;
`ifdef IF_ID_ALIGN_CHK_EN
    // A misaligned fetch is marked and its word replaced so ID never decodes it
    w_new.adel = |if_pc[1:0];
    w_new.ins  = w_new.adel ? INS_NOP : if_ins;
`else
    w_new.ins  = if_ins;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_bubble   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_tail] <= w_new;
          r_tail        <= f_inc(r_tail);
        end
        if (w_pop) r_head <= f_inc(r_head);
      end
      r_count  <= w_count_next;
      r_bubble <= (w_count_next == c_CW'(DEPTH));
      // A fetch arriving while full is an integration error; flush wins, so it is not flagged then
      if (if_ins_valid & ~flush & w_full) r_overflow <= 1'b1;
    end
  end

  assign id_valid  = (r_count != '0);
  assign id_pc     = r_mem[r_head].pc;
  assign id_ins    = r_mem[r_head].ins;
  assign if_bubble = r_bubble;
  assign overflow  = r_overflow;
`ifdef IF_ID_ALIGN_CHK_EN
  assign id_exc_adel = id_valid & r_mem[r_head].adel;
`endif

endmodule : if_id_buffer

`default_nettype wire
